// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-level round-robin merge of NUM_IN AXI-Stream sources into one sink.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready  NUM_IN source ports, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_tdata/m_tvalid/m_tlast/m_tready  merged sink port
//   grant_id              currently or most recently granted source
//   busy                  high while a packet is in progress
//
// Build option: define ARB_OUT_REG_EN to place a 2-entry skid buffer on the m_* side;
// otherwise the granted source is passed through combinationally.
module axis_pkt_arbiter #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_IN     = 4,
    localparam int IDW        = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_IN-1:0]            s_tvalid,
    input  logic [NUM_IN-1:0]            s_tlast,
    output logic [NUM_IN-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    input  logic                         m_tready,
    output logic [IDW-1:0]               grant_id,
    output logic                         busy
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        grant_q, grant_d;
    logic [IDW-1:0]        last_q, last_d;
    logic [IDW-1:0]        win;
    logic [IDW:0]          idx_sum;
    logic                  found;
    logic                  xfer;
    logic                  in_valid, in_last, in_ready;
    logic [DATA_WIDTH-1:0] in_data;

    assign xfer     = (state_q == XFER);
    assign busy     = xfer;
    assign grant_id = grant_q;

    // Datapath stage input: the granted source, gated so IDLE presents nothing.
    assign in_valid = xfer & s_tvalid[grant_q];
    assign in_last  = s_tlast[grant_q];
    assign in_data  = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        s_tready          = '0;
        s_tready[grant_q] = xfer & in_ready;
    end

    // Round-robin scan starting just above the last completed grant, wrapping at NUM_IN.
    always_comb begin
        win     = grant_q;
        found   = 1'b0;
        idx_sum = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx_sum = {1'b0, last_q} + (IDW+1)'(k);
            if (idx_sum >= (IDW+1)'(NUM_IN)) idx_sum = idx_sum - (IDW+1)'(NUM_IN);
            if (!found && s_tvalid[idx_sum[IDW-1:0]]) begin
                win   = idx_sum[IDW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (found) begin
                grant_d = win;
                state_d = XFER;
            end
        end else if (in_valid && in_ready && in_last) begin
            state_d = IDLE;
            last_d  = grant_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDW'(NUM_IN - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_OUT_REG_EN
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  skid_last_q, skid_last_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  rdy_q, rdy_d;
    logic                  push;

    // Ready is a flop: the skid entry absorbs the beat accepted while the output stalls.
    assign in_ready = rdy_q;
    assign push     = in_valid & rdy_q;
    assign m_tvalid = out_valid_q;
    assign m_tlast  = out_last_q;
    assign m_tdata  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || m_tready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_last_d   = skid_last_q;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = push;
                if (push) begin
                    out_last_d = in_last;
                    out_data_d = in_data;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_last_d  = in_last;
            skid_data_d  = in_data;
        end
        rdy_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
            rdy_q        <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
            rdy_q        <= rdy_d;
        end
    end
`else
    assign in_ready = m_tready;
    assign m_tvalid = in_valid;
    assign m_tlast  = xfer & in_last;
    assign m_tdata  = xfer ? in_data : '0;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: randomized scoreboard bench for axis_pkt_arbiter.
module tb_axis_pkt_arbiter;
    localparam int DW = 16;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]  s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [1:0]    grant_id;
    logic          busy;

    axis_pkt_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW:0] src_q [N][$];
    logic [DW:0] exp_q [$];
    int          dut_grants [$];
    int          gap [N];
    int          fixed_gap [N];
    bit          rand_gaps = 0;
    int          tready_mode = 0;
    bit          tr_phase = 0;
    bit          mb = 0;
    int          mg = 0;
    int          ml = N - 1;
    logic [N-1:0] smp_v, smp_r, smp_l;
    bit          smp_ok = 0;
    int          acc_cnt = 0;
    bit          prev_stall = 0;
    bit          prev_busy = 0;
    logic [DW-1:0] prev_d;
    logic        prev_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int rr(input int last, input logic [N-1:0] v);
        int j = last;
        for (int k = 0; k < N; k++) begin
            j = (j + 1) % N;
            if (v[j]) return j;
        end
        return last;
    endfunction

    task automatic send(input int src, input int len, input logic [DW-1:0] base);
        for (int k = 0; k < len; k++) src_q[src].push_back({k == len - 1, base + DW'(k)});
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1;
        return exp_q.size() != 0;
    endfunction

    task automatic wait_idle(input int max);
        int n = 0;
        while ((pending() || mb) && n < max) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d cycles required<%0d", n, max);
        end
    endtask

    // Per-cycle checks against the reference model, and scoreboard push on input acceptance.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            smp_ok     = 0;
            prev_stall = 0;
            prev_busy  = 0;
        end else begin
            logic [N-1:0] allowed;
            smp_v  = s_tvalid;
            smp_r  = s_tready;
            smp_l  = s_tlast;
            smp_ok = 1;
            chk("busy", busy, mb);
            chk("grant_id", grant_id, mg);
            allowed = mb ? N'(1) << mg : '0;
            chk("s_tready_mask", s_tready & ~allowed, 0);
`ifndef ARB_OUT_REG_EN
            if (mb) chk("s_tready_follow", s_tready[mg], m_tready);
            chk("m_tvalid_pass", m_tvalid, mb && s_tvalid[mg]);
`endif
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_data", m_tdata, prev_d);
                chk("stall_last", m_tlast, prev_l);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
            if (busy && !prev_busy) dut_grants.push_back(int'(grant_id));
            prev_busy = busy;
            for (int i = 0; i < N; i++)
                if (s_tvalid[i] && s_tready[i]) begin
                    exp_q.push_back({s_tlast[i], s_tdata[i*DW +: DW]});
                    acc_cnt++;
                end
        end
    end

    // Output monitor: pops the scoreboard on every downstream handshake.
    initial forever begin
        @(negedge clk);
        #1;
        if (!reset && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_beat actual=%0h required=no_beat", m_tdata);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                chk("out_data", m_tdata, e[DW-1:0]);
                chk("out_last", m_tlast, e[DW]);
            end
        end
    end

    // Source drivers and the arbitration model, advanced once per clock edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (!reset) begin
            if (smp_ok) begin
                if (mb) begin
                    if (smp_v[mg] && smp_r[mg] && smp_l[mg]) begin
                        mb = 0;
                        ml = mg;
                    end
                end else if (smp_v != 0) begin
                    mg = rr(ml, smp_v);
                    mb = 1;
                end
                for (int i = 0; i < N; i++) begin
                    if (smp_v[i] && smp_r[i]) begin
                        void'(src_q[i].pop_front());
                        gap[i] = rand_gaps ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0)
                                           : fixed_gap[i];
                    end else if (gap[i] > 0) gap[i]--;
                end
            end
            for (int i = 0; i < N; i++) begin
                logic [DW:0] b;
                bit v;
                v = src_q[i].size() != 0 && gap[i] == 0;
                b = v ? src_q[i][0] : '0;
                s_tvalid[i]          = v;
                s_tlast[i]           = b[DW];
                s_tdata[i*DW +: DW]  = b[DW-1:0];
            end
            tr_phase = ~tr_phase;
            m_tready = (tready_mode == 0) ? 1'b1 :
                       (tready_mode == 1) ? tr_phase : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            gap[i]       = 0;
            fixed_gap[i] = 0;
        end
        repeat (2) @(posedge clk);
        #3;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // Round robin: every source has two 2-beat packets waiting.
        dut_grants.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) send(s, 2, DW'(16'h0100 * (s + 1) + 16'h0010 * r));
        wait_idle(200);
        chk("rr_count", dut_grants.size(), 8);
        for (int k = 0; k < 8 && k < dut_grants.size(); k++) chk("rr_order", dut_grants[k], k % N);

        // Single 3-beat packet from source 0.
        dut_grants.delete();
        send(0, 3, 16'h0001);
        wait_idle(50);
        chk("single_grant_cnt", dut_grants.size(), 1);
        if (dut_grants.size() > 0) chk("single_grant", dut_grants[0], 0);

        // Backpressure: toggling m_tready during a 4-beat packet from source 2.
        tready_mode = 1;
        send(2, 4, 16'h2000);
        wait_idle(100);
        tready_mode = 0;

        // Source gap: source 1 pauses mid-packet while source 3 is waiting.
        dut_grants.delete();
        fixed_gap[1] = 5;
        send(1, 3, 16'h1000);
        repeat (3) @(posedge clk);
        send(3, 2, 16'h3000);
        wait_idle(100);
        fixed_gap[1] = 0;
        chk("gap_grant_cnt", dut_grants.size(), 2);
        if (dut_grants.size() == 2) begin
            chk("gap_first", dut_grants[0], 1);
            chk("gap_second", dut_grants[1], 3);
        end

        // Randomized traffic with random gaps and backpressure.
        rand_gaps   = 1;
        tready_mode = 2;
        for (int p = 0; p < 60; p++) send(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 5)), DW'($urandom));
        wait_idle(4000);
        rand_gaps   = 0;
        tready_mode = 0;

        // Reset during beat 2 of a 4-beat packet.
        send(0, 4, 16'h4000);
        n = acc_cnt;
        for (int c = 0; c < 50 && acc_cnt == n; c++) @(negedge clk);
        chk("rst_mid_beat1_seen", acc_cnt, n + 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_s_tready", s_tready, 0);
        chk("rst_mid_m_tvalid", m_tvalid, 0);
        chk("rst_mid_m_tlast", m_tlast, 0);
        chk("rst_mid_m_tdata", m_tdata, 0);
        chk("rst_mid_grant_id", grant_id, 0);
        chk("rst_mid_busy", busy, 0);
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            gap[i] = 0;
        end
        exp_q.delete();
        dut_grants.delete();
        mb = 0;
        mg = 0;
        ml = N - 1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        repeat (2) @(posedge clk);
        send(3, 2, 16'h3300);
        send(0, 2, 16'h0300);
        #3;
        reset = 1'b0;
        wait_idle(100);
        chk("post_rst_cnt", dut_grants.size(), 2);
        if (dut_grants.size() == 2) begin
            chk("post_rst_first", dut_grants[0], 0);
            chk("post_rst_second", dut_grants[1], 3);
        end

        chk("final_exp_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-level round-robin arbiter that merges NUM_IN AXI-Stream sources into one AXI-Stream sink, normally the write side of the stream FIFO. A grant is held from the first beat of a packet until the beat carrying tlast is accepted, so packets are never interleaved. The FIFO input port can therefore be shared by several producers without corrupting tlast framing.

## Interface
- DATA_WIDTH, 16, width of tdata on every port.
- NUM_IN, 4, number of source ports; legal range 2..16.
- IDW, derived, equals $clog2(NUM_IN); not overridable.

- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- s_tdata  input  NUM_IN*DATA_WIDTH  source data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  input  NUM_IN  per-source valid.
- s_tlast  input  NUM_IN  per-source end-of-packet.
- s_tready  output  NUM_IN  per-source ready; at most one bit high in any cycle.
- m_tdata  output  DATA_WIDTH  merged data to the FIFO.
- m_tvalid  output  1  merged valid.
- m_tlast  output  1  merged end-of-packet.
- m_tready  input  1  FIFO ready.
- grant_id  output  IDW  index of the currently or most recently granted source.
- busy  output  1  high while a packet is in progress (state XFER).

## Operation
- The state machine has two states, IDLE and XFER. Reset enters IDLE.
- IDLE:
  - All s_tready are 0. The arbiter presents nothing to the datapath stage.
  - If any s_tvalid is high, the winner is the first requester found scanning upward from (last_grant+1) mod NUM_IN, wrapping at NUM_IN-1.
  - grant_id is registered to the winner and the state moves to XFER on the next edge.
  - If no s_tvalid is high, the state stays IDLE.
- XFER with grant g:
  - The datapath stage receives s_tdata[g], s_tvalid[g] and s_tlast[g].
  - s_tready[g] is the stage's ready. s_tready of every other source is 0.
  - A beat is accepted when s_tvalid[g] and s_tready[g] are both high.
  - When the accepted beat has s_tlast[g]=1, last_grant is set to g and the state returns to IDLE.
  - When s_tvalid[g] is low mid-packet, the arbiter holds the grant and waits; there is no timeout.
- Fairness: a source that keeps requesting is granted at most NUM_IN-1 packets after it first asserts tvalid in IDLE.
- last_grant resets to NUM_IN-1, so source 0 has first priority after reset.
- busy is 1 exactly when the state is XFER.
- grant_id holds its value while in IDLE.

## Timing
- Reset values:
  - s_tready = 0, m_tvalid = 0, m_tlast = 0, m_tdata = 0.
  - grant_id = 0, busy = 0.
  - state = IDLE, last_grant = NUM_IN-1.
- Arbitration takes one cycle. The first beat of a packet can be accepted at the earliest in the cycle after the request is seen in IDLE.
- There is one IDLE bubble cycle between consecutive packets, even when they come from the same source.
- Within a packet, throughput is one beat per cycle while s_tvalid[g] and m_tready are both high.
- The arbiter obeys AXI-Stream rules: once m_tvalid rises, m_tdata and m_tlast stay stable until m_tready is high.
- A reset asserted mid-packet takes effect immediately:
  - The partial packet is abandoned and no completing tlast is generated.
  - The downstream FIFO is reset by the same signal.
- A source asserting tvalid while another source holds the grant is not reported anywhere. It waits with s_tready=0.

## Configuration
- ARB_OUT_REG_EN undefined:
  - The datapath stage is a combinational pass-through: m_* = s_*[g] and s_tready[g] = m_tready.
  - Latency is 0 cycles.
- ARB_OUT_REG_EN defined:
  - A 2-entry skid buffer sits on the m_* side. m_tdata, m_tvalid and m_tlast are driven directly from flops, and s_tready[g] is registered (high when the buffer has a free entry).
  - Latency from source acceptance to m_tvalid is 1 cycle. Full throughput is kept under continuous m_tready.
  - The state returns to IDLE when the tlast beat enters the buffer, not when it leaves. The next packet may be accepted behind it.
  - The buffer is emptied only by downstream handshakes. Reset clears it.

## Test plan
- Single source: source 0 sends a 3-beat packet (0x0001, 0x0002, 0x0003 with tlast) while m_tready=1. Required: identical beats on m_*, grant_id=0, busy high for exactly 3 cycles, then one IDLE cycle.
- Round-robin with NUM_IN=4: all four sources request continuously with 2-beat packets. Required grant order is 0, 1, 2, 3, 0, and no beats from different sources are interleaved.
- Backpressure: m_tready toggles 1,0,1,0 during a 4-beat packet from source 2. Required: each beat appears exactly once, m_tdata is stable while stalled, and s_tready[2] follows m_tready (registered variant: no beat is lost or duplicated).
- Source gap: source 1 drops tvalid for 5 cycles mid-packet while source 3 is requesting. Required: the grant stays at 1, s_tready[3]=0 throughout, and source 3 is granted only after source 1's tlast is accepted.
- Reset mid-operation: assert reset during beat 2 of a 4-beat packet. Required: all outputs go to their reset values immediately; after release, source 0 wins first even if source 3 also requests.
